// File: rtl/conv3x3_window_sequencer.sv
// Streams a raster-order image through two line buffers and a 3x3 window register,
// emitting one valid-padding patch per interior output pixel with ready/valid handshakes.
module conv3x3_window_sequencer #(
   parameter int unsigned MAX_W = 640,
   parameter int unsigned PIX_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [9:0]           cfg_width,
   input  logic [9:0]           cfg_height,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err,
   input  logic                 pix_valid,
   input  logic [PIX_W-1:0]     pix_data,
   output logic                 pix_ready,
   output logic                 patch_valid,
   input  logic                 patch_ready,
   output logic [9*PIX_W-1:0]   patch,
   output logic [9:0]           out_row,
   output logic [9:0]           out_col
);

   localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e           state_q, state_d;
   logic [9:0]       width_q, height_q;
   logic [9:0]       col_q, row_q;
   logic [9:0]       out_row_q, out_col_q;
   logic             patch_valid_q;
   logic             cfg_err_q;

   logic [PIX_W-1:0] line1_mem [MAX_W];
   logic [PIX_W-1:0] line2_mem [MAX_W];
   logic [PIX_W-1:0] win_q [3][3];

   logic             cfg_ok;
   logic             start_ok;
   logic             patch_hold;
   logic             accept;
   logic             col_last;
   logic             last_pix;
   logic             produce;
   logic [AW-1:0]    addr;
   logic [PIX_W-1:0] lb1_rd;
   logic [PIX_W-1:0] lb2_rd;

   assign cfg_ok     = (cfg_width >= 10'd3) && (32'(cfg_width) <= MAX_W) &&
                       (cfg_height >= 10'd3);
   assign start_ok   = (state_q == StIdle) && start && cfg_ok;
   assign patch_hold = patch_valid_q && !patch_ready;
   assign pix_ready  = (state_q == StRun) && !patch_hold;
   assign accept     = pix_valid && pix_ready;
   assign col_last   = (col_q == width_q - 10'd1);
   assign last_pix   = col_last && (row_q == height_q - 10'd1);
   // A patch exists once the window spans three full rows and three full columns.
   assign produce    = accept && (row_q >= 10'd2) && (col_q >= 10'd2);
   assign addr       = col_q[AW-1:0];
   assign lb1_rd     = line1_mem[addr];
   assign lb2_rd     = line2_mem[addr];

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start_ok) state_d = StRun;
         StRun:   if (accept && last_pix) state_d = StFlush;
         StFlush: if (!patch_valid_q || patch_ready) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         width_q   <= '0;
         height_q  <= '0;
         col_q     <= '0;
         row_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= (state_q == StIdle) && start && !cfg_ok;
         if (start_ok) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            col_q    <= '0;
            row_q    <= '0;
         end else if (accept) begin
            if (col_last) begin
               col_q <= '0;
               row_q <= row_q + 10'd1;
            end else begin
               col_q <= col_q + 10'd1;
            end
         end
      end
   end

   // Line 1 holds row r-1 and line 2 row r-2; each accept ages the column by one row.
   always_ff @(posedge clk) begin
      if (accept) begin
         line2_mem[addr] <= lb1_rd;
         line1_mem[addr] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else if (accept) begin
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
         end
         win_q[0][2] <= lb2_rd;
         win_q[1][2] <= lb1_rd;
         win_q[2][2] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         patch_valid_q <= 1'b0;
         out_row_q     <= '0;
         out_col_q     <= '0;
      end else if (produce) begin
         patch_valid_q <= 1'b1;
         out_row_q     <= row_q - 10'd2;
         out_col_q     <= col_q - 10'd2;
      end else if (patch_ready) begin
         patch_valid_q <= 1'b0;
      end
   end

   // The window is frozen while a patch is held, since no pixel is accepted then.
   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
         assign patch[(gi*3+gj)*PIX_W +: PIX_W] = win_q[gi][gj];
      end
   end

   assign busy        = (state_q == StRun) || (state_q == StFlush);
   assign done        = (state_q == StDone);
   assign cfg_err     = cfg_err_q;
   assign patch_valid = patch_valid_q;
   assign out_row     = out_row_q;
   assign out_col     = out_col_q;

endmodule

// File: tb/tb_conv3x3_window_sequencer.sv
// Randomized bench for conv3x3_window_sequencer; expected patches come from a
// direct image-array model indexed by output coordinate.
module tb_conv3x3_window_sequencer;

   localparam int unsigned MAX_W = 640;
   localparam int unsigned PIX_W = 8;
   localparam int unsigned PW    = 9 * PIX_W;

   typedef logic [PW-1:0]    patch_t;
   typedef logic [PIX_W-1:0] pix_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [9:0]   cfg_width;
   logic [9:0]   cfg_height;
   logic         busy;
   logic         done;
   logic         cfg_err;
   logic         pix_valid;
   logic [PIX_W-1:0] pix_data;
   logic         pix_ready;
   logic         patch_valid;
   logic         patch_ready;
   logic [PW-1:0] patch;
   logic [9:0]   out_row;
   logic [9:0]   out_col;

   always #5 clk = ~clk;

   conv3x3_window_sequencer #(
      .MAX_W(MAX_W),
      .PIX_W(PIX_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .patch_valid(patch_valid),
      .patch_ready(patch_ready),
      .patch      (patch),
      .out_row    (out_row),
      .out_col    (out_col)
   );

   int     n_tests = 0;
   int     n_fail  = 0;

   pix_t   img[$];
   patch_t exp_patch[$];
   int     exp_row[$];
   int     exp_col[$];
   patch_t obs_patch[$];
   int     obs_row[$];
   int     obs_col[$];
   logic   stall_ready[$];
   patch_t stall_patch[$];
   int     obs_done;
   int     obs_bubbles;
   int     obs_cfg_err;
   int     obs_unstable;
   int     obs_accepted;
   logic   obs_busy_start;

   task automatic make_img(input int w, input int h, input bit ramp);
      img.delete();
      for (int k = 0; k < w * h; k++) begin
         if (ramp) img.push_back(pix_t'(k));
         else      img.push_back(pix_t'($urandom));
      end
   endtask

   // Patch (orow, ocol) element [i][j] is image pixel (orow+i, ocol+j).
   task automatic model_frame(input int w, input int h);
      patch_t p;
      exp_patch.delete();
      exp_row.delete();
      exp_col.delete();
      for (int orow = 0; orow < h - 2; orow++) begin
         for (int ocol = 0; ocol < w - 2; ocol++) begin
            p = '0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  p[(i*3+j)*PIX_W +: PIX_W] = img[(orow + i) * w + ocol + j];
               end
            end
            exp_patch.push_back(p);
            exp_row.push_back(orow);
            exp_col.push_back(ocol);
         end
      end
   endtask

   task automatic run_frame(input int w, input int h, input int valid_pct, input int ready_pct,
                            input int stall_first, input int restart_at);
      int     idx;
      int     stall_left;
      bit     stall_used;
      bit     restarted;
      int     post;
      bit     hold_prev;
      patch_t prev_patch;
      logic [9:0] prev_row;
      logic [9:0] prev_col;
      idx = 0; stall_left = 0; stall_used = 0; restarted = 0; post = -1;
      hold_prev = 0; prev_patch = '0; prev_row = '0; prev_col = '0;
      obs_patch.delete(); obs_row.delete(); obs_col.delete();
      stall_ready.delete(); stall_patch.delete();
      obs_done = 0; obs_bubbles = 0; obs_cfg_err = 0; obs_unstable = 0;
      @(negedge clk);
      start = 1'b1; cfg_width = 10'(w); cfg_height = 10'(h);
      @(negedge clk);
      start = 1'b0;
      obs_busy_start = busy;
      for (int cyc = 0; cyc < 10 * w * h + 200; cyc++) begin
         if (done) begin
            obs_done++;
            if (post < 0) post = 4;
         end
         if (cfg_err) obs_cfg_err++;
         if (post == 0) break;
         if (post > 0) post--;
         if (hold_prev && (patch !== prev_patch || out_row !== prev_row ||
                           out_col !== prev_col || patch_valid !== 1'b1)) obs_unstable++;
         start = 1'b0;
         if (restart_at >= 0 && !restarted && idx == restart_at) begin
            start = 1'b1; cfg_width = 10'd3; cfg_height = 10'd3; restarted = 1;
         end
         pix_valid = (idx < w * h) && (int'($urandom_range(99)) < valid_pct);
         if (pix_valid) pix_data = img[idx];
         else           pix_data = pix_t'($urandom);
         if (stall_first > 0 && !stall_used && patch_valid) begin
            stall_left = stall_first;
            stall_used = 1;
         end
         if (stall_left > 0) patch_ready = 1'b0;
         else                patch_ready = (int'($urandom_range(99)) < ready_pct);
         #1;
         if (stall_left > 0) begin
            stall_ready.push_back(pix_ready);
            stall_patch.push_back(patch);
            stall_left--;
         end
         if (pix_valid && pix_ready) idx++;
         if (pix_valid && patch_ready && !pix_ready) obs_bubbles++;
         if (patch_valid && patch_ready) begin
            obs_patch.push_back(patch);
            obs_row.push_back(int'(out_row));
            obs_col.push_back(int'(out_col));
         end
         hold_prev  = patch_valid && !patch_ready;
         prev_patch = patch;
         prev_row   = out_row;
         prev_col   = out_col;
         @(negedge clk);
      end
      obs_accepted = idx;
      pix_valid = 1'b0; patch_ready = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; cfg_width = 10'd8; cfg_height = 10'd8;
      pix_valid = 1'b1; patch_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({busy, done, cfg_err, pix_ready, patch_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got busy/done/err/prdy/pval=%b want 00000",
                  {busy, done, cfg_err, pix_ready, patch_valid});
      end
      n_tests++;
      if (patch !== '0 || out_row !== 10'd0 || out_col !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got patch=%h row=%0d col=%0d want 0/0/0",
                  patch, out_row, out_col);
      end
      start = 1'b0; pix_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      #1;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_basic;
      pix_t   s0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      pix_t   s3 [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
      patch_t p0;
      patch_t p3;
      for (int k = 0; k < 9; k++) begin
         p0[k*PIX_W +: PIX_W] = s0[k];
         p3[k*PIX_W +: PIX_W] = s3[k];
      end
      make_img(4, 4, 1);
      model_frame(4, 4);
      run_frame(4, 4, 100, 100, 0, -1);
      n_tests++;
      if (obs_busy_start !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy: got %b want 1", obs_busy_start);
      end
      n_tests++;
      if (obs_patch.size() != 4) begin
         n_fail++;
         $display("FAIL basic_count: got %0d want 4", obs_patch.size());
      end else begin
         n_tests++;
         if (obs_patch[0] !== p0 || obs_row[0] != 0 || obs_col[0] != 0) begin
            n_fail++;
            $display("FAIL basic_p00: got %h @(%0d,%0d) want %h @(0,0)",
                     obs_patch[0], obs_row[0], obs_col[0], p0);
         end
         n_tests++;
         if (obs_patch[3] !== p3 || obs_row[3] != 1 || obs_col[3] != 1) begin
            n_fail++;
            $display("FAIL basic_p11: got %h @(%0d,%0d) want %h @(1,1)",
                     obs_patch[3], obs_row[3], obs_col[3], p3);
         end
      end
      for (int k = 0; k < obs_patch.size() && k < exp_patch.size(); k++) begin
         n_tests++;
         if (obs_patch[k] !== exp_patch[k] || obs_row[k] != exp_row[k] ||
             obs_col[k] != exp_col[k]) begin
            n_fail++;
            $display("FAIL basic_patch[%0d]: got %h @(%0d,%0d) want %h @(%0d,%0d)", k,
                     obs_patch[k], obs_row[k], obs_col[k], exp_patch[k], exp_row[k], exp_col[k]);
         end
      end
      n_tests++;
      if (obs_done != 1) begin
         n_fail++;
         $display("FAIL basic_done: got %0d pulses want 1", obs_done);
      end
      n_tests++;
      if (obs_bubbles != 0) begin
         n_fail++;
         $display("FAIL basic_bubbles: got %0d want 0", obs_bubbles);
      end
   endtask

   task automatic test_backpressure;
      make_img(4, 4, 1);
      model_frame(4, 4);
      run_frame(4, 4, 100, 100, 5, -1);
      n_tests++;
      if (stall_ready.size() != 5) begin
         n_fail++;
         $display("FAIL bp_stall_len: got %0d want 5", stall_ready.size());
      end
      for (int k = 0; k < stall_ready.size(); k++) begin
         n_tests++;
         if (stall_ready[k] !== 1'b0 || stall_patch[k] !== exp_patch[0]) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got pix_ready=%b patch=%h want 0 %h", k,
                     stall_ready[k], stall_patch[k], exp_patch[0]);
         end
      end
      n_tests++;
      if (obs_accepted != 16 || obs_patch.size() != 4) begin
         n_fail++;
         $display("FAIL bp_counts: got %0d pixels %0d patches want 16 4",
                  obs_accepted, obs_patch.size());
      end
      for (int k = 0; k < obs_patch.size() && k < exp_patch.size(); k++) begin
         n_tests++;
         if (obs_patch[k] !== exp_patch[k] || obs_row[k] != exp_row[k] ||
             obs_col[k] != exp_col[k]) begin
            n_fail++;
            $display("FAIL bp_patch[%0d]: got %h @(%0d,%0d) want %h @(%0d,%0d)", k,
                     obs_patch[k], obs_row[k], obs_col[k], exp_patch[k], exp_row[k], exp_col[k]);
         end
      end
      n_tests++;
      if (obs_done != 1 || obs_unstable != 0) begin
         n_fail++;
         $display("FAIL bp_done_stable: got done=%0d unstable=%0d want 1 0",
                  obs_done, obs_unstable);
      end
   endtask

   task automatic test_cfg_err;
      int bad_w [4] = '{2, int'(MAX_W) + 1, 5, 0};
      int bad_h [4] = '{8, 3, 2, 0};
      for (int t = 0; t < 4; t++) begin
         int ec = 0;
         int bc = 0;
         @(negedge clk);
         start = 1'b1; cfg_width = 10'(bad_w[t]); cfg_height = 10'(bad_h[t]);
         #1;
         ec += int'(cfg_err); bc += int'(busy);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            ec += int'(cfg_err); bc += int'(busy);
         end
         n_tests++;
         if (ec != 1 || bc != 0) begin
            n_fail++;
            $display("FAIL cfg_err[%0d] W=%0d H=%0d: got err cycles=%0d busy cycles=%0d want 1 0",
                     t, bad_w[t], bad_h[t], ec, bc);
         end
      end
   endtask

   task automatic test_max_width;
      int bad_rows;
      make_img(MAX_W, 3, 0);
      model_frame(MAX_W, 3);
      run_frame(MAX_W, 3, 100, 100, 0, -1);
      n_tests++;
      if (obs_patch.size() != int'(MAX_W) - 2) begin
         n_fail++;
         $display("FAIL maxw_count: got %0d want %0d", obs_patch.size(), MAX_W - 2);
      end
      bad_rows = 0;
      for (int k = 0; k < obs_patch.size(); k++) if (obs_row[k] != 0) bad_rows++;
      n_tests++;
      if (bad_rows != 0) begin
         n_fail++;
         $display("FAIL maxw_rows: got %0d nonzero out_row want 0", bad_rows);
      end
      for (int k = 0; k < obs_patch.size() && k < exp_patch.size(); k++) begin
         n_tests++;
         if (obs_patch[k] !== exp_patch[k] || obs_col[k] != exp_col[k]) begin
            n_fail++;
            $display("FAIL maxw_patch[%0d]: got %h col %0d want %h col %0d", k,
                     obs_patch[k], obs_col[k], exp_patch[k], exp_col[k]);
         end
      end
      n_tests++;
      if (obs_done != 1 || obs_bubbles != 0) begin
         n_fail++;
         $display("FAIL maxw_done: got done=%0d bubbles=%0d want 1 0", obs_done, obs_bubbles);
      end
   endtask

   task automatic test_mid_reset;
      int acc = 0;
      int dn  = 0;
      @(negedge clk);
      start = 1'b1; cfg_width = 10'd5; cfg_height = 10'd5;
      @(negedge clk);
      start = 1'b0; patch_ready = 1'b1;
      for (int cyc = 0; cyc < 50 && acc < 7; cyc++) begin
         pix_valid = 1'b1;
         pix_data  = pix_t'($urandom);
         #1;
         if (pix_ready) acc++;
         if (done) dn++;
         @(negedge clk);
      end
      pix_valid = 1'b0;
      n_tests++;
      if (acc != 7 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre: got %0d pixels busy=%b want 7 1", acc, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_tests++;
      if ({busy, pix_ready, patch_valid} !== 3'b0 || patch !== '0 ||
          out_row !== 10'd0 || out_col !== 10'd0) begin
         n_fail++;
         $display("FAIL midrst_state: got busy/prdy/pval=%b patch=%h want 000 0",
                  {busy, pix_ready, patch_valid}, patch);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) dn++;
      end
      n_tests++;
      if (dn != 0) begin
         n_fail++;
         $display("FAIL midrst_nodone: got %0d done pulses want 0", dn);
      end
      make_img(3, 3, 0);
      model_frame(3, 3);
      run_frame(3, 3, 100, 100, 0, -1);
      n_tests++;
      if (obs_patch.size() != 1 || obs_done != 1) begin
         n_fail++;
         $display("FAIL midrst_frame: got %0d patches %0d done want 1 1",
                  obs_patch.size(), obs_done);
      end else begin
         n_tests++;
         if (obs_patch[0] !== exp_patch[0] || obs_row[0] != 0 || obs_col[0] != 0) begin
            n_fail++;
            $display("FAIL midrst_patch: got %h @(%0d,%0d) want %h @(0,0)",
                     obs_patch[0], obs_row[0], obs_col[0], exp_patch[0]);
         end
      end
   endtask

   task automatic test_start_ignored;
      make_img(6, 4, 0);
      model_frame(6, 4);
      run_frame(6, 4, 80, 70, 0, 5);
      n_tests++;
      if (obs_patch.size() != 8 || obs_accepted != 24 || obs_done != 1 || obs_cfg_err != 0) begin
         n_fail++;
         $display("FAIL ign_counts: got %0d patches %0d pixels %0d done %0d err want 8 24 1 0",
                  obs_patch.size(), obs_accepted, obs_done, obs_cfg_err);
      end
      for (int k = 0; k < obs_patch.size() && k < exp_patch.size(); k++) begin
         n_tests++;
         if (obs_patch[k] !== exp_patch[k] || obs_row[k] != exp_row[k] ||
             obs_col[k] != exp_col[k]) begin
            n_fail++;
            $display("FAIL ign_patch[%0d]: got %h @(%0d,%0d) want %h @(%0d,%0d)", k,
                     obs_patch[k], obs_row[k], obs_col[k], exp_patch[k], exp_row[k], exp_col[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int f = 0; f < 4; f++) begin
         int w = int'($urandom_range(12, 3));
         int h = int'($urandom_range(6, 3));
         make_img(w, h, 0);
         model_frame(w, h);
         run_frame(w, h, 60, 50, 0, -1);
         n_tests++;
         if (obs_patch.size() != (w - 2) * (h - 2) || obs_accepted != w * h ||
             obs_done != 1 || obs_unstable != 0 || obs_bubbles != 0) begin
            n_fail++;
            $display("FAIL b2b[%0d] %0dx%0d: got %0d patches %0d pix %0d done %0d unstable %0d bubbles want %0d %0d 1 0 0",
                     f, w, h, obs_patch.size(), obs_accepted, obs_done, obs_unstable,
                     obs_bubbles, (w - 2) * (h - 2), w * h);
         end
         for (int k = 0; k < obs_patch.size() && k < exp_patch.size(); k++) begin
            n_tests++;
            if (obs_patch[k] !== exp_patch[k] || obs_row[k] != exp_row[k] ||
                obs_col[k] != exp_col[k]) begin
               n_fail++;
               $display("FAIL b2b[%0d]_patch[%0d]: got %h @(%0d,%0d) want %h @(%0d,%0d)", f, k,
                        obs_patch[k], obs_row[k], obs_col[k], exp_patch[k], exp_row[k],
                        exp_col[k]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
      pix_valid = 1'b0; pix_data = '0; patch_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_cfg_err();
      test_max_width();
      test_mid_reset();
      test_start_ignored();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/conv3x3_window_sequencer.md
CONV3X3_WINDOW_SEQUENCER -- requirements
Module: conv3x3_window_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter MAX_W, default 640, SHALL set the maximum image width in pixels and the line-buffer depth.
REQ-003 Parameter PIX_W, default 8, SHALL set the pixel width in bits.
REQ-004 Port clk, input, 1, SHALL be the clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port start, input, 1, SHALL request a frame; it is sampled only in IDLE.
REQ-007 Port cfg_width, input, 10, SHALL give the image width W, latched on an accepted start.
REQ-008 Port cfg_height, input, 10, SHALL give the image height H, latched on an accepted start.
REQ-009 Port busy, output, 1, SHALL be high in RUN and FLUSH.
REQ-010 Port done, output, 1, SHALL pulse for one cycle at frame end.
REQ-011 Port cfg_err, output, 1, SHALL pulse for one cycle when start carries an illegal configuration.
REQ-012 Port pix_valid, input, 1, SHALL mark a valid raster-order input pixel.
REQ-013 Port pix_data, input, PIX_W, SHALL carry the input pixel.
REQ-014 Port pix_ready, output, 1, SHALL mark that the block accepts a pixel this cycle.
REQ-015 Port patch_valid, output, 1, SHALL mark a valid 3x3 patch for the convolution engine.
REQ-016 Port patch_ready, input, 1, SHALL mark that the engine consumes the patch this cycle.
REQ-017 Port patch, output, 9*PIX_W, SHALL carry the patch; element [i][j] sits at bits (i*3+j)*PIX_W and matches kernel[i][j] ordering.
REQ-018 Ports out_row and out_col, output, 10 each, SHALL give the output coordinate of the current patch.

Function
REQ-019 States SHALL be IDLE, RUN, FLUSH and DONE.
REQ-020 In IDLE, start with 3<=W<=MAX_W and H>=3 SHALL latch the configuration, clear the row/column counters and go to RUN.
REQ-021 In IDLE, start with an illegal configuration SHALL pulse cfg_err, stay in IDLE and leave the latched configuration unchanged.
REQ-022 Start SHALL be ignored in RUN, FLUSH and DONE.
REQ-023 pix_ready SHALL equal (state==RUN) && !(patch_valid && !patch_ready).
REQ-024 A pixel SHALL be accepted on pix_valid && pix_ready.
REQ-025 An accepted pixel SHALL advance the input column c, wrap c to 0 at W-1, and then increment row r.
REQ-026 Two line buffers, each MAX_W x PIX_W, SHALL hold rows r-1 and r-2.
REQ-027 The 3x3 window registers SHALL shift left by one column on each accept, loading the new column {linebuf2[c], linebuf1[c], pix_data}.
REQ-028 Accepting the pixel at (r,c) with r>=2 and c>=2 SHALL assert patch_valid on the next cycle.
REQ-029 That patch SHALL be pixels (r-2+i, c-2+j) for i,j in 0..2, with out_row=r-2 and out_col=c-2.
REQ-030 Valid padding only: a frame SHALL produce exactly (H-2)*(W-2) patches.
REQ-031 patch, out_row and out_col SHALL hold stable while patch_valid && !patch_ready.
REQ-032 patch_valid SHALL drop the cycle after patch_ready unless a new patch is produced in the same cycle.
REQ-033 A pixel accept and a patch consume in the same cycle SHALL be legal, with no bubble.
REQ-034 Accepting pixel (H-1, W-1) SHALL move to FLUSH.
REQ-035 FLUSH SHALL wait until the final patch is consumed, then go to DONE.
REQ-036 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-037 pix_ready SHALL stay low outside RUN, so no pixels beyond W*H are accepted.
REQ-038 Line-buffer contents SHALL be don't-care at frame start; no output patch may depend on them.

Reset
REQ-039 On rst, state SHALL go to IDLE and the counters SHALL clear.
REQ-040 On rst, busy, done, cfg_err, pix_ready and patch_valid SHALL be 0.
REQ-041 On rst, patch, out_row and out_col SHALL be 0.
REQ-042 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-043 After a mid-frame reset, a new start SHALL begin a clean frame.

Verification
REQ-044 W=4, H=4, pixels 0..15, patch_ready=1 -> 4 patches.
  - (0,0) = {0,1,2,4,5,6,8,9,10}; (1,1) = {5,6,7,9,10,11,13,14,15}.
  - done pulses exactly once.
REQ-045 Same stimulus, patch_ready low for 5 cycles at the first patch_valid -> pix_ready=0 and the patch holds stable for those 5 cycles, with no pixel lost.
REQ-046 start with W=2, H=8 -> cfg_err=1 for one cycle; busy stays 0.
REQ-047 start with W=MAX_W, H=3, random pixels -> MAX_W-2 patches that match a reference model, with out_row=0 throughout.
REQ-048 Reset in RUN after 7 accepted pixels, then start with W=3, H=3 -> exactly one patch equal to the 9 new pixels, and done pulses once.
REQ-049 start pulsed during RUN -> ignored; configuration and counters unchanged.
